counter_arbiter: RTL and testbench
==================================

Name: counter_arbiter

Overview:
- Shares one saturating up/down counter (range 0..MAXV) between two requesters.
- Each request asks for one step up or one step down; the block arbitrates, sequences the step through a 3-state FSM and returns a one-cycle ack with an error flag when the step is refused at a limit.
- Typical use: occupancy or credit tracking where two independent agents adjust a shared count.

Parameters:
- WIDTH, 4, counter width in bits.
- MAXV, 7, upper saturation value; must satisfy MAXV < 2**WIDTH (elaboration-time assertion).

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- req  input  2  request level per requester; held high until acked
- dir  input  2  direction per requester; 1=up, 0=down; sampled at grant only
- ack  output 2  one-cycle completion pulse to the granted requester
- err  output 1  valid with ack; 1 = step refused (saturation), count unchanged
- grant_id  output 1  index of the requester currently being served
- count  output WIDTH  current counter value
- busy  output 1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, count=0, ack=0, err=0, grant_id=0, busy=0, last_grant=1 (requester 0 wins the first tie).
- FSM states are IDLE, UPDATE and ACK.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - If exactly one req bit is set, grant that requester.
  - If both req bits are set, grant the requester that is not last_grant (round-robin).
  - On grant, latch grant_id and dir[grant_id], then move to UPDATE.
- UPDATE:
  - Drive a one-cycle step enable to the counter with the latched direction.
  - If up with count==MAXV, or down with count==0, the count holds and err_next=1.
  - Otherwise count changes by ±1 at the closing edge.
  - Next state is ACK.
- ACK:
  - ack[grant_id]=1 and err are valid for exactly this cycle.
  - The new count is already visible.
  - last_grant<=grant_id; next state is IDLE.
- Latency and throughput:
  - A req sampled in IDLE at edge E0 produces a count update at E1 and ack high during the E1..E2 cycle.
  - Throughput is one operation per 3 cycles.
- Handshake:
  - The requester must drop req at the edge that ends its ack cycle.
  - A req still high in the following IDLE cycle is treated as a new request.
  - req and dir changes while busy=1 are ignored; the other requester's req simply waits.
- Outputs:
  - ack=0 and err=0 in IDLE and UPDATE.
  - grant_id holds its last value in IDLE.
- Reset mid-operation (in UPDATE or ACK): the pending ack is dropped, count=0 and state=IDLE; no partial step survives.
- Width rule: the step never wraps; count stays within 0..MAXV at all times.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both req bits are set, and last_grant is unused.
- Undefined: round-robin as described under Behaviour.
- All other timing is identical in both builds.

Decomposition:
- Shared package counter_arb_pkg:
  - state enum {IDLE, UPDATE, ACK};
  - direction constants DIR_UP=1, DIR_DOWN=0;
  - N_REQ=2.
- Sub-module sat_updown_counter:
  - inputs clk, rst, en, up; output count;
  - parameters WIDTH and MAXV;
  - output at_limit, combinational: (up && count==MAXV) || (!up && count==0).
  - The arbiter uses at_limit to generate err.

Test Plan:
- Single up step from reset: req[0]=1, dir[0]=1 → ack[0] high 2 cycles after grant sample, err=0, count=1.
- Saturation: 8 successive up requests on requester 0 → count=7; 8th ack has err=1 and count stays 7.
- Underflow: requester 1 down at count=0 → ack[1] with err=1, count=0.
- Tie with round-robin:
  - setup: from reset, both req held with dir[0]=1, dir[1]=0, count=3;
  - stimulus: each requester re-raises req after its ack;
  - required: grants 0,1,0,1 and count sequence 4,3,4,3.
- Reset mid-operation: rst asserted during UPDATE → next cycle count=0, state IDLE, no ack pulse ever issued.
- ARB_FIXED_PRIO_EN build, same tie stimulus → grants 0,0,0; requester 1 is served only after req[0] drops.

Source files
------------

// File: rtl/counter_arb_pkg.sv
// Shared types and constants for the two-requester counter arbiter.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
package counter_arb_pkg;

    localparam int   N_REQ    = 2;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        ACK    = 2'd2
    } state_e;

    // One-hot ack vector for the served requester.
    function automatic logic [N_REQ-1:0] ack_vec(input logic id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter over 0..MAXV; at_limit flags a step that would leave the range.
module sat_updown_counter
    import counter_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAXV  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAXV);
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign at_limit = ((up == DIR_UP)   && (count_q == MAX_VAL)) ||
                      ((up == DIR_DOWN) && (count_q == '0));

    always_comb begin
        count_d = count_q;
        if (en && !at_limit) begin
            count_d = (up == DIR_UP) ? count_q + STEP : count_q - STEP;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_arbiter.sv
// Arbitrates two requesters onto one saturating counter: IDLE -> UPDATE -> ACK per step.
// Build option: ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin on ties.
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAXV  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] dir,
    output logic [N_REQ-1:0] ack,
    output logic             err,
    output logic             grant_id,
    output logic [WIDTH-1:0] count,
    output logic             busy
);

    if (MAXV >= (2 ** WIDTH)) begin : g_bad_maxv
        $error("counter_arbiter: MAXV must be less than 2**WIDTH");
    end

    state_e           state_q;
    logic             grant_id_q;
    logic             grant_d;
    logic             dir_q;
    logic [N_REQ-1:0] ack_q;
    logic             err_q;
    logic             busy_q;
    logic             step_en;
    logic             at_limit;
`ifndef ARB_FIXED_PRIO_EN
    logic             last_grant_q;
`endif

    // Winner selection; only consumed in IDLE when some req is set.
    always_comb begin
        grant_d = grant_id_q;
        unique case (req)
            2'b01:   grant_d = 1'b0;
            2'b10:   grant_d = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
            2'b11:   grant_d = 1'b0;
`else
            2'b11:   grant_d = ~last_grant_q;
`endif
            default: grant_d = grant_id_q;
        endcase
    end

    assign step_en = (state_q == UPDATE);

    sat_updown_counter #(
        .WIDTH (WIDTH),
        .MAXV  (MAXV)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (step_en),
        .up       (dir_q),
        .count    (count),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_id_q   <= 1'b0;
            dir_q        <= DIR_DOWN;
            ack_q        <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_id_q <= grant_d;
                        dir_q      <= dir[grant_d];
                        busy_q     <= 1'b1;
                        state_q    <= UPDATE;
                    end
                end
                UPDATE: begin
                    // The counter steps on this same edge; err reflects the pre-step limit check.
                    ack_q   <= ack_vec(grant_id_q);
                    err_q   <= at_limit;
                    state_q <= ACK;
                end
                ACK: begin
                    ack_q        <= '0;
                    err_q        <= 1'b0;
                    busy_q       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
                    last_grant_q <= grant_id_q;
`endif
                    state_q      <= IDLE;
                end
                default: begin
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed self-checking bench for counter_arbiter; expectations follow ARB_FIXED_PRIO_EN when defined.
module tb_counter_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] dir;
    logic [1:0] ack;
    logic       err;
    logic       grant_id;
    logic [3:0] count;
    logic       busy;

    int checks = 0;
    int errors = 0;

    counter_arbiter #(
        .WIDTH (4),
        .MAXV  (7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .dir      (dir),
        .ack      (ack),
        .err      (err),
        .grant_id (grant_id),
        .count    (count),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b1;
        req = 2'b00;
        dir = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One request from requester id; returns ack-cycle observations and the following IDLE cycle.
    task automatic run_op(input int id, input logic up,
                          output logic [1:0] a, output logic e, output logic [3:0] c,
                          output logic g, output int waited,
                          output logic [1:0] a_after, output logic b_after);
        req[id] = 1'b1;
        dir[id] = up;
        waited  = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                waited = k;
                break;
            end
        end
        checks++;
        if (waited == 0) begin
            errors++;
            $display("FAIL op_timeout requester=%0d: no ack within 10 cycles", id);
        end
        a = ack;
        e = err;
        c = count;
        g = grant_id;
        req[id] = 1'b0;
        @(negedge clk);
        a_after = ack;
        b_after = busy;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({count, ack, err, busy, grant_id} !== 9'b0) begin
            errors++;
            $display("FAIL reset_state got count=%0d ack=%b err=%b busy=%b gid=%b expected all zero",
                     count, ack, err, busy, grant_id);
        end
    endtask

    task automatic test_single_up();
        logic [1:0] a, a2;
        logic       e, g, b2;
        logic [3:0] c;
        int         w;
        apply_reset();
        run_op(0, 1'b1, a, e, c, g, w, a2, b2);
        checks++;
        if (w != 2) begin
            errors++;
            $display("FAIL single_latency got %0d cycles expected 2", w);
        end
        checks++;
        if ({a, e, g} !== 4'b01_0_0) begin
            errors++;
            $display("FAIL single_ack got ack=%b err=%b gid=%b expected ack=01 err=0 gid=0", a, e, g);
        end
        checks++;
        if (c !== 4'd1) begin
            errors++;
            $display("FAIL single_count got %0d expected 1", c);
        end
        checks++;
        if ({a2, b2} !== 3'b000) begin
            errors++;
            $display("FAIL single_after got ack=%b busy=%b expected ack=00 busy=0", a2, b2);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] a, a2;
        logic       e, g, b2;
        logic [3:0] c;
        int         w;
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            run_op(0, 1'b1, a, e, c, g, w, a2, b2);
            checks++;
            if (c !== ((i < 8) ? 4'(i) : 4'd7) || e !== (i == 8) || a !== 2'b01) begin
                errors++;
                $display("FAIL sat_step%0d got count=%0d err=%b ack=%b expected count=%0d err=%b ack=01",
                         i, c, e, a, (i < 8) ? i : 7, (i == 8));
            end
        end
    endtask

    task automatic test_underflow();
        logic [1:0] a, a2;
        logic       e, g, b2;
        logic [3:0] c;
        int         w;
        apply_reset();
        run_op(1, 1'b0, a, e, c, g, w, a2, b2);
        checks++;
        if ({a, e, g} !== 4'b10_1_1 || c !== 4'd0) begin
            errors++;
            $display("FAIL underflow got ack=%b err=%b gid=%b count=%0d expected ack=10 err=1 gid=1 count=0",
                     a, e, g, c);
        end
    endtask

    task automatic test_tie();
        logic [1:0] a, a2;
        logic       e, g, b2;
        logic [3:0] c;
        int         w;
        logic       served;
        logic       got_ack;
`ifdef ARB_FIXED_PRIO_EN
        logic [3:0] exp_g = 4'b0000;
        logic [3:0] exp_c [4] = '{4'd4, 4'd5, 4'd6, 4'd7};
        logic       drain_g = 1'b1;
        logic [3:0] drain_c = 4'd6;
`else
        logic [3:0] exp_g = 4'b1010;
        logic [3:0] exp_c [4] = '{4'd4, 4'd3, 4'd4, 4'd3};
        logic       drain_g = 1'b0;
        logic [3:0] drain_c = 4'd4;
`endif
        apply_reset();
        for (int i = 0; i < 4; i++) run_op(0, 1'b1, a, e, c, g, w, a2, b2);
        run_op(1, 1'b0, a, e, c, g, w, a2, b2);
        checks++;
        if (c !== 4'd3) begin
            errors++;
            $display("FAIL tie_setup got count=%0d expected 3", c);
        end
        req = 2'b11;
        dir = 2'b01;
        for (int i = 0; i < 4; i++) begin
            got_ack = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (ack !== 2'b00) begin
                    got_ack = 1'b1;
                    break;
                end
            end
            checks++;
            if (!got_ack || grant_id !== exp_g[i] || count !== exp_c[i] || err !== 1'b0 ||
                ack !== (exp_g[i] ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL tie_op%0d got ack=%b gid=%b count=%0d err=%b expected gid=%b count=%0d err=0",
                         i, ack, grant_id, count, err, exp_g[i], exp_c[i]);
            end
            served      = ack[1];
            req[served] = 1'b0;
            @(negedge clk);
            if (i < 3) req[served] = 1'b1;
        end
        got_ack = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                got_ack = 1'b1;
                break;
            end
        end
        checks++;
        if (!got_ack || grant_id !== drain_g || count !== drain_c) begin
            errors++;
            $display("FAIL tie_drain got ack=%b gid=%b count=%0d expected gid=%b count=%0d",
                     ack, grant_id, count, drain_g, drain_c);
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic saw_ack;
        req = 2'b01;
        dir = 2'b01;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ack !== 2'b00) begin
            errors++;
            $display("FAIL midrst_update got busy=%b ack=%b expected busy=1 ack=00", busy, ack);
        end
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({count, busy, ack, err} !== 8'b0) begin
            errors++;
            $display("FAIL midrst_state got count=%0d busy=%b ack=%b err=%b expected all zero",
                     count, busy, ack, err);
        end
        saw_ack = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack !== 2'b00 || busy !== 1'b0) saw_ack = 1'b1;
        end
        checks++;
        if (saw_ack !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_ack got activity after reset expected none");
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b00;
        dir = 2'b00;
        @(negedge clk);
        test_reset();
        test_single_up();
        test_saturation();
        test_underflow();
        test_tie();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
